// File: rtl/gdp_controller.sv
// gdp_controller: Moore-style control FSM for the GDP accumulator processor.
// Optional build macro GDP_SINGLE_STEP_EN adds a Step input that gates each fetch.
module gdp_controller (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [2:0] IR,
    input  logic       Aeq0,
    input  logic       Apos,
    input  logic       Enter,
`ifdef GDP_SINGLE_STEP_EN
    input  logic       Step,
`endif
    output logic       PCload,
    output logic       JMPmux,
    output logic       IRload,
    output logic       Meminst,
    output logic       MemWr,
    output logic       Aload,
    output logic       Sub,
    output logic [1:0] Asel,
    output logic       Halt,
    output logic       InReq,
    output logic [3:0] State
);
    localparam logic [3:0] S_START  = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_LOAD   = 4'd3;
    localparam logic [3:0] S_STORE  = 4'd4;
    localparam logic [3:0] S_ADD    = 4'd5;
    localparam logic [3:0] S_SUB    = 4'd6;
    localparam logic [3:0] S_INPUT  = 4'd7;
    localparam logic [3:0] S_JZ     = 4'd8;
    localparam logic [3:0] S_JPOS   = 4'd9;
    localparam logic [3:0] S_HALT   = 4'd10;

    logic [3:0] state, state_nxt;
    logic       go;

`ifdef GDP_SINGLE_STEP_EN
    assign go = Step;
`else
    assign go = 1'b1;
`endif

    assign State = state;

    // State register, asynchronously forced to START while Reset is low
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) state <= S_START;
        else        state <= state_nxt;
    end

    // Next-state: opcode maps onto execute states 3..10 in order
    always_comb begin
        state_nxt = S_START;
        case (state)
            S_START:  state_nxt = S_FETCH;
            S_FETCH:  state_nxt = go ? S_DECODE : S_FETCH;
            S_DECODE: state_nxt = {1'b0, IR} + 4'd3;
            S_LOAD, S_STORE, S_ADD, S_SUB, S_JZ, S_JPOS: state_nxt = S_FETCH;
            S_INPUT:  state_nxt = Enter ? S_FETCH : S_INPUT;
            S_HALT:   state_nxt = S_HALT;
            default:  state_nxt = S_START;
        endcase
    end

    // Output decode: Moore except PCload in jumps and Aload in INPUT
    always_comb begin
        PCload  = 1'b0;
        JMPmux  = 1'b0;
        IRload  = 1'b0;
        Meminst = 1'b0;
        MemWr   = 1'b0;
        Aload   = 1'b0;
        Sub     = 1'b0;
        Asel    = 2'b00;
        Halt    = 1'b0;
        InReq   = 1'b0;
        case (state)
            S_FETCH: begin
                IRload = go;
                PCload = go;
            end
            S_DECODE: Meminst = 1'b1;
            S_LOAD: begin
                Meminst = 1'b1;
                Asel    = 2'b10;
                Aload   = 1'b1;
            end
            S_STORE: begin
                Meminst = 1'b1;
                MemWr   = 1'b1;
            end
            S_ADD: begin
                Meminst = 1'b1;
                Aload   = 1'b1;
            end
            S_SUB: begin
                Meminst = 1'b1;
                Sub     = 1'b1;
                Aload   = 1'b1;
            end
            S_INPUT: begin
                InReq = 1'b1;
                Asel  = Enter ? 2'b01 : 2'b00;
                Aload = Enter;
            end
            S_JZ: begin
                JMPmux = 1'b1;
                PCload = Aeq0;
            end
            S_JPOS: begin
                JMPmux = 1'b1;
                PCload = Apos;
            end
            S_HALT:  Halt = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_gdp_controller.sv
// tb_gdp_controller: directed bench for gdp_controller (also covers GDP_SINGLE_STEP_EN builds).
module tb_gdp_controller;
    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic [2:0] IR    = 3'b000;
    logic       Aeq0  = 1'b0;
    logic       Apos  = 1'b0;
    logic       Enter = 1'b0;
    logic       Step  = 1'b1;
    logic       PCload, JMPmux, IRload, Meminst, MemWr, Aload, Sub, Halt, InReq;
    logic [1:0] Asel;
    logic [3:0] State;
    int         checks = 0;
    int         errors = 0;

    gdp_controller dut (
        .Clock(Clock), .Reset(Reset), .IR(IR), .Aeq0(Aeq0), .Apos(Apos), .Enter(Enter),
`ifdef GDP_SINGLE_STEP_EN
        .Step(Step),
`endif
        .PCload(PCload), .JMPmux(JMPmux), .IRload(IRload), .Meminst(Meminst), .MemWr(MemWr),
        .Aload(Aload), .Sub(Sub), .Asel(Asel), .Halt(Halt), .InReq(InReq), .State(State)
    );

    always #5 Clock = ~Clock;

    // Packed outputs: PCload JMPmux IRload Meminst MemWr Aload Sub Asel[1:0] Halt InReq
    localparam logic [10:0] O_NONE  = 11'h000;
    localparam logic [10:0] O_FETCH = 11'h500;
    localparam logic [10:0] O_DEC   = 11'h080;
    localparam logic [10:0] O_LOAD  = 11'h0A8;
    localparam logic [10:0] O_STORE = 11'h0C0;
    localparam logic [10:0] O_ADD   = 11'h0A0;
    localparam logic [10:0] O_SUB   = 11'h0B0;
    localparam logic [10:0] O_INW   = 11'h001;
    localparam logic [10:0] O_INE   = 11'h025;
    localparam logic [10:0] O_JT    = 11'h600;
    localparam logic [10:0] O_JN    = 11'h200;
    localparam logic [10:0] O_HALT  = 11'h002;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] es, input logic [10:0] eo);
        logic [10:0] o;
        o = {PCload, JMPmux, IRload, Meminst, MemWr, Aload, Sub, Asel, Halt, InReq};
        checks++;
        assert (State === es) else begin
            errors++;
            $error("FAIL %s state observed %0d expected %0d", tag, State, es);
        end
        checks++;
        assert (o === eo) else begin
            errors++;
            $error("FAIL %s outputs observed %03h expected %03h", tag, o, eo);
        end
    endtask

    // From FETCH with IR set: DECODE, execute, back to FETCH
    task automatic run_instr(input string tag, input logic [2:0] op, input logic [3:0] es, input logic [10:0] eo);
        IR = op;
        tick(); chk({tag, "_decode"}, 4'd2, O_DEC);
        tick(); chk({tag, "_exec"}, es, eo);
        tick(); chk({tag, "_fetch"}, 4'd1, O_FETCH);
    endtask

    task automatic release_reset();
        @(negedge Clock);
        Reset = 1'b1;
        tick(); chk("rst_fetch1", 4'd1, O_FETCH);
    endtask

    initial begin
        #3;
        chk("in_reset", 4'd0, O_NONE);
        tick(); tick();
        chk("in_reset_clocked", 4'd0, O_NONE);
        release_reset();
        run_instr("load", 3'b000, 4'd3, O_LOAD);
        run_instr("store", 3'b001, 4'd4, O_STORE);
        run_instr("add", 3'b010, 4'd5, O_ADD);
        run_instr("sub", 3'b011, 4'd6, O_SUB);
        IR = 3'b100;
        tick(); chk("in_decode", 4'd2, O_DEC);
        for (int i = 0; i < 5; i++) begin
            tick(); chk("in_wait", 4'd7, O_INW);
        end
        Enter = 1'b1;
        #1 chk("in_enter", 4'd7, O_INE);
        tick(); chk("in_fetch", 4'd1, O_FETCH);
        Enter = 1'b0;
        IR = 3'b101; Aeq0 = 1'b1;
        tick(); chk("jz_decode", 4'd2, O_DEC);
        tick(); chk("jz_taken", 4'd8, O_JT);
        Aeq0 = 1'b0; Apos = 1'b1;
        #1 chk("jz_not", 4'd8, O_JN);
        tick(); chk("jz_fetch", 4'd1, O_FETCH);
        IR = 3'b110;
        tick(); chk("jpos_decode", 4'd2, O_DEC);
        tick(); chk("jpos_taken", 4'd9, O_JT);
        Apos = 1'b0; Aeq0 = 1'b1;
        #1 chk("jpos_not", 4'd9, O_JN);
        tick(); chk("jpos_fetch", 4'd1, O_FETCH);
        Aeq0 = 1'b0;
        IR = 3'b100;
        tick(); tick();
        chk("mid_input", 4'd7, O_INW);
        Reset = 1'b0;
        #1 chk("mid_input_reset", 4'd0, O_NONE);
        release_reset();
        IR = 3'b111;
        tick(); chk("halt_decode", 4'd2, O_DEC);
        for (int i = 0; i < 20; i++) begin
            tick(); chk("halt_hold", 4'd10, O_HALT);
        end
        #1 Reset = 1'b0;
        #1 chk("halt_async_reset", 4'd0, O_NONE);
`ifdef GDP_SINGLE_STEP_EN
        IR = 3'b000; Step = 1'b0;
        @(negedge Clock);
        Reset = 1'b1;
        tick(); chk("step_stall1", 4'd1, O_NONE);
        tick(); chk("step_stall2", 4'd1, O_NONE);
        Step = 1'b1;
        #1 chk("step_go", 4'd1, O_FETCH);
        tick(); Step = 1'b0;
        chk("step_decode", 4'd2, O_DEC);
        tick(); chk("step_exec", 4'd3, O_LOAD);
        tick(); chk("step_stall3", 4'd1, O_NONE);
        tick(); chk("step_stall4", 4'd1, O_NONE);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
